// File: rtl/wbsp_i2c_cmdq.sv
// Wishbone write-only slave: command FIFO feeding the I2C byte engine, plus prescale/control registers.
// Build option I2C_CMDQ_OVF_ERR_EN: command writes never stall; a push while full is dropped and answered with err.
module wbsp_i2c_cmdq #(
    parameter int          AW           = 26,
    parameter int          DW           = 32,
    parameter int          LGFIFO       = 3,
    parameter logic [15:0] PRESCALE_RST = 16'd250
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [DW/8-1:0] i_wb_sel,
    output logic            o_wb_ack,
    output logic            o_wb_stall,
    output logic            o_wb_err,
    output logic            o_cmd_valid,
    input  logic            i_cmd_ready,
    output logic [11:0]     o_cmd_data,
    output logic [15:0]     o_prescale,
    output logic            o_enable,
    output logic [LGFIFO:0] o_fifo_level
);
    localparam int DEPTH = 1 << LGFIFO;

    logic [LGFIFO:0] wr_ptr, rd_ptr;
    logic [11:0]     mem [DEPTH];
    logic [1:0]      addr;
    logic            full, empty, acc, has_sel, ovf;
    logic            push, pop, flush, ack_d, err_d;
    logic            unused_bits;

    assign addr        = i_wb_addr[1:0];
    assign unused_bits = &{1'b0, i_wb_addr[AW-1:2], i_wb_data[DW-1:16]};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[LGFIFO] != rd_ptr[LGFIFO]) &&
                   (wr_ptr[LGFIFO-1:0] == rd_ptr[LGFIFO-1:0]);

`ifdef I2C_CMDQ_OVF_ERR_EN
    assign o_wb_stall = 1'b0;
    assign ovf        = (addr == 2'd0) && full;
`else
    // Conservative: a pop in the same cycle does not lift the stall.
    assign o_wb_stall = i_wb_stb && (addr == 2'd0) && full;
    assign ovf        = 1'b0;
`endif

    assign acc     = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign has_sel = |i_wb_sel;
    assign err_d   = acc && ((addr == 2'd3) || ovf);
    assign ack_d   = acc && !err_d;

    // An all-zero byte-enable write is acknowledged but has no side effect.
    assign push  = acc && has_sel && (addr == 2'd0) && !full;
    assign flush = acc && has_sel && (addr == 2'd2) && i_wb_data[1];

    assign o_cmd_valid  = !empty && o_enable;
    assign pop          = o_cmd_valid && i_cmd_ready && !flush;
    assign o_cmd_data   = mem[rd_ptr[LGFIFO-1:0]];
    assign o_fifo_level = wr_ptr - rd_ptr;

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr[LGFIFO-1:0]] <= i_wb_data[11:0];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_prescale <= PRESCALE_RST;
            o_enable   <= 1'b0;
            o_wb_ack   <= 1'b0;
            o_wb_err   <= 1'b0;
        end else begin
            o_wb_ack <= ack_d;
            o_wb_err <= err_d;
            if (acc && has_sel && addr == 2'd1)
                o_prescale <= i_wb_data[15:0];
            if (acc && has_sel && addr == 2'd2)
                o_enable <= i_wb_data[0];
        end
    end

endmodule

// File: doc/wbsp_i2c_cmdq.md
Name: wbsp_i2c_cmdq

Overview:
- Wishbone pipelined, write-only slave that sits directly downstream of the AXI-lite write bridge and consumes its o_wb_* strobes.
- Decodes a 4-word register window.
  - Command writes are queued into a show-ahead FIFO that feeds the I2C byte engine over a valid/ready stream.
  - Prescale and control writes land in registers.
- Back-pressure is via stall; bad addresses return err.

Parameters:
- AW, 26, Wishbone word-address width (matches the bridge's AW).
- DW, 32, Wishbone data width.
- LGFIFO, 3, log2 of command FIFO depth (depth = 2^LGFIFO).
- PRESCALE_RST, 16'd250, reset value of o_prescale.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  request strobe.
- i_wb_addr  in  AW  word address; only [1:0] decoded, upper bits ignored.
- i_wb_data  in  DW  write data.
- i_wb_sel  in  DW/8  byte enables.
- o_wb_ack  out  1  write acknowledge.
- o_wb_stall  out  1  request not accepted this cycle.
- o_wb_err  out  1  bus error.
- o_cmd_valid  out  1  command available to I2C engine.
- i_cmd_ready  in  1  engine consumes head command.
- o_cmd_data  out  12  {nack,read,stop,start,byte[7:0]}.
- o_prescale  out  16  SCL prescale divisor.
- o_enable  out  1  engine enable.
- o_fifo_level  out  LGFIFO+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO empty, o_fifo_level=0, o_cmd_valid=0, o_wb_ack=0, o_wb_err=0, o_prescale=PRESCALE_RST, o_enable=0. o_cmd_data is don't-care while empty.
- Accept condition: acc = i_wb_cyc && i_wb_stb && !o_wb_stall. All cycles are writes; there is no read path.
- o_wb_stall is combinational: 1 when i_wb_stb && addr==0 && FIFO full. A same-cycle pop does not clear it, so stall is conservative. It is 0 otherwise.
- Address map:
  - 0 CMD: push i_wb_data[11:0] into the FIFO.
  - 1 PRESCALE: o_prescale <= i_wb_data[15:0].
  - 2 CTRL: o_enable <= data[0]; data[1]=1 flushes the FIFO (self-clearing, not stored).
  - 3: invalid.
- Register side effects commit on the acc cycle and are visible the next cycle.
- Response latency is exactly 1 cycle after acc:
  - o_wb_ack <= acc && valid address.
  - o_wb_err <= acc && invalid address.
  - Each is a single-cycle pulse; ack and err are never high together.
  - Back-to-back accepted strobes produce back-to-back responses, one per strobe, in order.
- If i_wb_cyc is low, no acceptance occurs. An ack/err already registered still pulses once, and nothing is pending after it.
- FIFO: circular, 2^LGFIFO entries, read/write pointers LGFIFO+1 bits wide with wrap bit.
  - full = pointers equal except MSB; empty = pointers equal.
  - o_fifo_level = wr_ptr - rd_ptr, modulo 2^(LGFIFO+1).
- Stream output:
  - o_cmd_valid = !empty && o_enable.
  - o_cmd_data = head entry.
  - Pop when o_cmd_valid && i_cmd_ready.
  - o_cmd_data is held stable while valid && !ready.
- Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged.
- Push into an empty FIFO: o_cmd_valid rises the next cycle (if enabled); push data does not bypass to the output.
- Flush: pointers reset the cycle after acc. A flush wins over a coincident pop; a coincident push is impossible since there is one strobe per cycle.
- o_enable=0: pushes are still accepted (up to full), and no pops occur.
- Byte enables: writes apply regardless of i_wb_sel, except an all-zero i_wb_sel, which is acked with no side effect.
- Reset mid-operation: all state returns to reset values immediately. An in-flight ack/err is dropped.

Optional Feature:
- Macro I2C_CMDQ_OVF_ERR_EN.
- Defined: CMD writes never stall. A push while the FIFO is full is accepted, discarded, and answered with o_wb_err one cycle later; o_wb_stall is tied 0.
- Undefined: stall-on-full as described above; o_wb_err arises only from address 3.

Test Plan:
- After reset: write addr1 data 0x0000_0064 → one ack 1 cycle later, o_prescale=0x0064. Write addr2 data 0x1 → o_enable=1.
- Enabled, i_cmd_ready=0: push 0x1A5 (start, byte 0xA5) → o_cmd_valid=1 next cycle, o_cmd_data=0x1A5, level=1. Raise ready → valid=0 next cycle, level=0.
- Ready=0, LGFIFO=3: push 9 commands back-to-back → 8 acks; 9th strobe stalls with level=8. One pop → 9th accepted, acked 1 cycle later, level=8. With I2C_CMDQ_OVF_ERR_EN: 9th strobe gets err, level stays 8.
- Write addr3 data 0xDEAD → o_wb_err pulse 1 cycle later, no ack, registers unchanged.
- Level=5, enabled, ready=1 held: write addr2 data 0x3 → level=0 the cycle after acc; no pop counted in that cycle.
- Alternating push/pop with continuous ready, 20 commands → pointer wrap verified, data out matches in-order input, level never exceeds 1.
